// File: rtl/demorgan_sweep_ctrl.sv
// Sweep sequencer and self-checker for the shared demorgan gate datapath.
// Optional first-failure snapshot enabled by defining DEMORGAN_SWEEP_SNAP_EN.
module demorgan_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       n_a,
    input  logic       n_b,
    input  logic       n_a_and_n_b,
    input  logic       n_a_or_n_b,
    input  logic       n_aorb,
    input  logic       n_aandb,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_mask,
    output logic [2:0] err_cnt,
    output logic       all_pass,
    output logic [8:0] err_snap
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] idx_nxt;
    logic [3:0] cnt;
    logic [5:0] obs;
    logic [5:0] ref_vec;
    logic       vec_ok;

    // Reference is derived from idx, not a_out, so a stuck driver shows up as a failure.
    always_comb begin
        obs     = {n_a, n_b, n_a_and_n_b, n_a_or_n_b, n_aorb, n_aandb};
        ref_vec = {~idx[1], ~idx[0], ~(idx[1] | idx[0]), ~(idx[1] & idx[0]),
                   ~(idx[1] | idx[0]), ~(idx[1] & idx[0])};
        vec_ok  = (obs == ref_vec);
        idx_nxt = idx + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_mask <= 4'd0;
            err_cnt   <= 3'd0;
            all_pass  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        idx       <= 2'd0;
                        cnt       <= SETTLE_L;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        pass_mask <= 4'd0;
                        err_cnt   <= 3'd0;
                        all_pass  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt <= 4'd1) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (vec_ok) pass_mask[idx] <= 1'b1;
                        else        err_cnt        <= err_cnt + 3'd1;
                        if (idx == 2'd3) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            all_pass <= vec_ok && (pass_mask[2:0] == 3'b111);
                        end else begin
                            idx   <= idx_nxt;
                            cnt   <= SETTLE_L;
                            a_out <= idx_nxt[1];
                            b_out <= idx_nxt[0];
                            state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMORGAN_SWEEP_SNAP_EN
    // Bit 0 doubles as the "already captured" flag so only the first failure sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_snap <= 9'h000;
        end else if (state == IDLE && start) begin
            err_snap <= 9'h000;
        end else if (state == SAMPLE && !abort && !vec_ok && !err_snap[0]) begin
            err_snap <= {idx, obs, 1'b1};
        end
    end
`else
    assign err_snap = 9'h000;
`endif

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Randomized self-checking bench: two sweepers (SETTLE=1 and SETTLE=3), each with a
// faultable demorgan model, checked against a vector-level reference of the sweep.
module tb_demorgan_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start     [2];
    logic       abort     [2];
    logic       a_out     [2];
    logic       b_out     [2];
    logic       busy      [2];
    logic       done      [2];
    logic [3:0] pass_mask [2];
    logic [2:0] err_cnt   [2];
    logic       all_pass  [2];
    logic [8:0] err_snap  [2];
    logic [5:0] flip      [2][4];
    logic [1:0][5:0] dm;

    int n_chk = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden demorgan outputs {n_a,n_b,n_a_and_n_b,n_a_or_n_b,n_aorb,n_aandb} for vector v={A,B}.
    function automatic logic [5:0] golden(input int v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {!a, !b, !(a || b), !(a && b), !(a || b), !(a && b)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign dm[g] = golden({30'd0, a_out[g], b_out[g]}) ^ flip[g][{a_out[g], b_out[g]}];
        demorgan_sweep_ctrl #(.SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
            .n_a(dm[g][5]), .n_b(dm[g][4]), .n_a_and_n_b(dm[g][3]),
            .n_a_or_n_b(dm[g][2]), .n_aorb(dm[g][1]), .n_aandb(dm[g][0]),
            .a_out(a_out[g]), .b_out(b_out[g]), .busy(busy[g]), .done(done[g]),
            .pass_mask(pass_mask[g]), .err_cnt(err_cnt[g]), .all_pass(all_pass[g]),
            .err_snap(err_snap[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_busy", busy[d], 0);
        chk("rst_done", done[d], 0);
        chk("rst_a", a_out[d], 0);
        chk("rst_b", b_out[d], 0);
        chk("rst_mask", pass_mask[d], 0);
        chk("rst_err", err_cnt[d], 0);
        chk("rst_allp", all_pass[d], 0);
        chk("rst_snap", err_snap[d], 0);
    endtask

    // One sweep on sweeper d, called just after a falling edge. abort_at = edge number at
    // which abort is sampled (0 = none); stray pulses start at edges 2 and 5.
    task automatic sweep(input int d, input int abort_at, input bit stray, input bit abort_w_start);
        int s, n, v, ecnt, first;
        bit aborted, cur_ab;
        logic [3:0] emask;
        logic [8:0] esnap;
        s = (d == 0) ? 1 : 3;
        n = 4 * (s + 1);
        aborted = (abort_at != 0) && (abort_at <= n);
        start[d] = 1'b1;
        abort[d] = abort_w_start;
        @(posedge clk);
        @(negedge clk);
        start[d] = 1'b0;
        abort[d] = 1'b0;
        chk("busy_c0", busy[d], 1);
        chk("vec_c0", {a_out[d], b_out[d]}, 0);
        for (int k = 1; k <= n + 1; k++) begin
            start[d] = stray && (k == 2 || k == 5);
            abort[d] = (k == abort_at);
            @(posedge clk);
            @(negedge clk);
            start[d] = 1'b0;
            abort[d] = 1'b0;
            cur_ab = aborted && (k >= abort_at);
            chk("busy", busy[d], (!cur_ab && k <= n) ? 1 : 0);
            chk("done", done[d], (!cur_ab && k == n) ? 1 : 0);
            if (!cur_ab && k < n) chk("vec", {a_out[d], b_out[d]}, k / (s + 1));
            if (!aborted && k == n + 1) chk("vec_hold", {a_out[d], b_out[d]}, 3);
        end
        emask = 4'd0;
        ecnt  = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (!aborted || (i + 1) * (s + 1) < abort_at) begin
                if (flip[d][i] == 6'd0) emask[i] = 1'b1;
                else begin
                    ecnt++;
                    if (first < 0) first = i;
                end
            end
        end
        esnap = 9'h000;
`ifdef DEMORGAN_SWEEP_SNAP_EN
        if (first >= 0) esnap = {first[1:0], golden(first) ^ flip[d][first], 1'b1};
`endif
        chk("pass_mask", pass_mask[d], emask);
        chk("err_cnt", err_cnt[d], ecnt);
        chk("all_pass", all_pass[d], (!aborted && emask == 4'hF) ? 1 : 0);
        chk("err_snap", err_snap[d], esnap);
    endtask

    task automatic set_flips(input int d, input logic [5:0] f0, input logic [5:0] f1,
                             input logic [5:0] f2, input logic [5:0] f3);
        flip[d][0] = f0;
        flip[d][1] = f1;
        flip[d][2] = f2;
        flip[d][3] = f3;
    endtask

    initial begin
        int d, ab, n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            set_flips(i, 6'd0, 6'd0, 6'd0, 6'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_reset(0);
        chk_reset(1);

        sweep(0, 0, 0, 0);
        set_flips(0, 6'b000001, 6'b000001, 6'b000001, 6'd0);
        sweep(0, 0, 0, 0);
        sweep(1, 0, 0, 0);
        sweep(1, 0, 0, 0);
        set_flips(0, 6'd0, 6'd0, 6'd0, 6'd0);
        sweep(0, 0, 1, 0);
        sweep(0, 3, 0, 0);
        sweep(0, 9, 0, 1);

        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(0, 1);
            n = (d == 0) ? 8 : 16;
            for (int v = 0; v < 4; v++)
                flip[d][v] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
            sweep(d, ab, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of vector 2's drive phase.
        set_flips(0, 6'd0, 6'd0, 6'd0, 6'd0);
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vec", {a_out[0], b_out[0]}, 2);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
